// File: rtl/vc_fifo.sv
// Per-virtual-channel input FIFO feeding one port of the output mux.
// Registered read word with a one-cycle valid pulse, occupancy flags and a sticky overflow error.
module vc_fifo #(
  parameter int DATA_WIDTH = 10,
  parameter int DEPTH      = 8,
  parameter int ADDR_WIDTH = 3,
  parameter int AF_THRESH  = 6,
  parameter int AE_THRESH  = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid_out,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow
);

  localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] AF_C    = (ADDR_WIDTH+1)'(AF_THRESH);
  localparam logic [ADDR_WIDTH:0] AE_C    = (ADDR_WIDTH+1)'(AE_THRESH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
  logic                  do_push, do_pop;

  assign full         = (count == DEPTH_C);
  assign empty        = (count == '0);
  assign almost_full  = (count >= AF_C);
  assign almost_empty = (count <= AE_C);

  // A pop on the same edge frees the slot, so a full FIFO still accepts the push.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || pop);

  // Storage carries no reset; its contents are never observed before being written.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= data_in;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      data_out  <= '0;
      valid_out <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      valid_out <= do_pop;
      if (do_pop) begin
        data_out <= mem[rd_ptr];
        rd_ptr   <= rd_ptr + ADDR_WIDTH'(1);
      end
      if (do_push) wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
      if (push && full && !pop) overflow <= 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + (ADDR_WIDTH+1)'(1);
        2'b01:   count <= count - (ADDR_WIDTH+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_vc_fifo.sv
// Directed bench for vc_fifo: reset, fill/drain, overflow, full/empty corner cases, pointer wrap.
module tb_vc_fifo;
  logic       clk = 1'b0;
  logic       reset;
  logic       push;
  logic [9:0] data_in;
  logic       pop;
  logic [9:0] data_out;
  logic       valid_out, full, empty, almost_full, almost_empty, overflow;
  logic [3:0] count;

  int n_pass = 0;
  int n_total = 0;

  vc_fifo dut (
    .clk(clk), .reset(reset), .push(push), .data_in(data_in), .pop(pop),
    .data_out(data_out), .valid_out(valid_out), .full(full), .empty(empty),
    .almost_full(almost_full), .almost_empty(almost_empty), .count(count),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic p, input logic [9:0] d, input logic r);
    push = p; data_in = d; pop = r;
  endtask

  task automatic apply_reset();
    drive(1'b0, 10'h0, 1'b0);
    reset = 1'b0;
    step();
    #1 reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    drive(1'b0, 10'h0, 1'b0);
    #1;
    n_total++;
    if ({count, empty, full, almost_full, almost_empty, valid_out, data_out, overflow}
        !== {4'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 10'h0, 1'b0})
      $display("FAIL reset_state: cnt=%0d e=%b f=%b af=%b ae=%b v=%b d=%h ov=%b (want 0 1 0 0 1 0 000 0)",
               count, empty, full, almost_full, almost_empty, valid_out, data_out, overflow);
    else n_pass++;
    step();
    #1 reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 10'(10'h0A0 + i), 1'b0);
      step();
    end
    drive(1'b0, 10'h0, 1'b1);
    step();
    n_total++;
    if (data_out !== 10'h0A0 || valid_out !== 1'b1 || count !== 4'd2)
      $display("FAIL pre_reset_pop: d=%h v=%b cnt=%0d want 0a0 1 2", data_out, valid_out, count);
    else n_pass++;
    drive(1'b0, 10'h0, 1'b0);
    reset = 1'b0;
    #1;
    n_total++;
    if (count !== 4'd0 || empty !== 1'b1 || valid_out !== 1'b0 || data_out !== 10'h0)
      $display("FAIL async_reset: cnt=%0d e=%b v=%b d=%h want 0 1 0 000", count, empty, valid_out, data_out);
    else n_pass++;
    #1 reset = 1'b1;
    drive(1'b0, 10'h0, 1'b1);
    step();
    n_total++;
    if (valid_out !== 1'b0 || count !== 4'd0)
      $display("FAIL pop_after_reset: v=%b cnt=%0d want 0 0", valid_out, count);
    else n_pass++;
    drive(1'b0, 10'h0, 1'b0);
  endtask

  task automatic test_fill_drain();
    apply_reset();
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, 10'(i), 1'b0);
      step();
      n_total++;
      if (count !== 4'(i) || almost_full !== (i >= 6) || full !== (i == 8) || empty !== 1'b0)
        $display("FAIL fill_%0d: cnt=%0d af=%b f=%b e=%b want %0d %b %b 0",
                 i, count, almost_full, full, empty, i, (i >= 6), (i == 8));
      else n_pass++;
    end
    for (int i = 1; i <= 8; i++) begin
      drive(1'b0, 10'h0, 1'b1);
      step();
      n_total++;
      if (data_out !== 10'(i) || valid_out !== 1'b1 || count !== 4'(8 - i) ||
          almost_empty !== ((8 - i) <= 2) || empty !== (i == 8))
        $display("FAIL drain_%0d: d=%h v=%b cnt=%0d ae=%b e=%b want %h 1 %0d %b %b",
                 i, data_out, valid_out, count, almost_empty, empty, 10'(i), 8 - i,
                 ((8 - i) <= 2), (i == 8));
      else n_pass++;
    end
    drive(1'b0, 10'h0, 1'b0);
    step();
    n_total++;
    if (valid_out !== 1'b0 || data_out !== 10'h008)
      $display("FAIL drain_idle: v=%b d=%h want 0 008", valid_out, data_out);
    else n_pass++;
  endtask

  task automatic test_overflow();
    apply_reset();
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, 10'(i), 1'b0);
      step();
    end
    drive(1'b1, 10'h3FF, 1'b0);
    step();
    n_total++;
    if (count !== 4'd8 || overflow !== 1'b1 || full !== 1'b1)
      $display("FAIL overflow_set: cnt=%0d ov=%b f=%b want 8 1 1", count, overflow, full);
    else n_pass++;
    drive(1'b0, 10'h0, 1'b0);
    step();
    n_total++;
    if (overflow !== 1'b1)
      $display("FAIL overflow_sticky: ov=%b want 1", overflow);
    else n_pass++;
    for (int i = 1; i <= 8; i++) begin
      drive(1'b0, 10'h0, 1'b1);
      step();
      n_total++;
      if (data_out !== 10'(i) || valid_out !== 1'b1)
        $display("FAIL ovf_drain_%0d: d=%h v=%b want %h 1", i, data_out, valid_out, 10'(i));
      else n_pass++;
    end
    step();
    n_total++;
    if (valid_out !== 1'b0 || data_out !== 10'h008 || overflow !== 1'b1)
      $display("FAIL ovf_no_extra: v=%b d=%h ov=%b want 0 008 1", valid_out, data_out, overflow);
    else n_pass++;
    drive(1'b0, 10'h0, 1'b0);
  endtask

  task automatic test_full_push_pop();
    apply_reset();
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, 10'(i), 1'b0);
      step();
    end
    drive(1'b1, 10'h2AA, 1'b1);
    step();
    n_total++;
    if (data_out !== 10'h001 || valid_out !== 1'b1 || count !== 4'd8 || overflow !== 1'b0)
      $display("FAIL full_pushpop: d=%h v=%b cnt=%0d ov=%b want 001 1 8 0",
               data_out, valid_out, count, overflow);
    else n_pass++;
    for (int k = 1; k <= 8; k++) begin
      drive(1'b0, 10'h0, 1'b1);
      step();
      n_total++;
      if (data_out !== ((k == 8) ? 10'h2AA : 10'(k + 1)) || count !== 4'(8 - k))
        $display("FAIL full_pp_drain_%0d: d=%h cnt=%0d want %h %0d",
                 k, data_out, count, ((k == 8) ? 10'h2AA : 10'(k + 1)), 8 - k);
      else n_pass++;
    end
    drive(1'b0, 10'h0, 1'b0);
  endtask

  task automatic test_empty_pop();
    // FIFO is empty here with data_out = 0x2AA from the previous test
    drive(1'b0, 10'h0, 1'b1);
    step();
    n_total++;
    if (valid_out !== 1'b0 || data_out !== 10'h2AA || overflow !== 1'b0)
      $display("FAIL empty_pop: v=%b d=%h ov=%b want 0 2aa 0", valid_out, data_out, overflow);
    else n_pass++;
    drive(1'b1, 10'h155, 1'b1);
    step();
    n_total++;
    if (valid_out !== 1'b0 || count !== 4'd1 || data_out !== 10'h2AA)
      $display("FAIL empty_pushpop: v=%b cnt=%0d d=%h want 0 1 2aa", valid_out, count, data_out);
    else n_pass++;
    drive(1'b0, 10'h0, 1'b1);
    step();
    n_total++;
    if (valid_out !== 1'b1 || data_out !== 10'h155 || count !== 4'd0)
      $display("FAIL empty_followup: v=%b d=%h cnt=%0d want 1 155 0", valid_out, data_out, count);
    else n_pass++;
    drive(1'b0, 10'h0, 1'b0);
  endtask

  task automatic test_wrap();
    apply_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 10'(10'h100 + i), 1'b0);
      step();
    end
    for (int k = 0; k < 20; k++) begin
      drive(1'b1, 10'(10'h103 + k), 1'b1);
      step();
      n_total++;
      if (data_out !== 10'(10'h100 + k) || valid_out !== 1'b1 || count !== 4'd3)
        $display("FAIL wrap_%0d: d=%h v=%b cnt=%0d want %h 1 3",
                 k, data_out, valid_out, count, 10'(10'h100 + k));
      else n_pass++;
    end
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, 10'h0, 1'b1);
      step();
      n_total++;
      if (data_out !== 10'(10'h114 + k) || count !== 4'(2 - k))
        $display("FAIL wrap_tail_%0d: d=%h cnt=%0d want %h %0d",
                 k, data_out, count, 10'(10'h114 + k), 2 - k);
      else n_pass++;
    end
    drive(1'b0, 10'h0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_overflow();
    test_full_push_pop();
    test_empty_pop();
    test_wrap();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
